encode_check_scheduler: RTL
===========================

Name: encode_check_scheduler

Overview:
- Sequences the encoder continuity checker through repeated measurement windows.
- Per window: issues the clean pulse, gates scanning to the window, counts encoder samples, waits for the checker pipeline to settle, latches max/cnt/lock results.
- Delivers each result as a report over a valid/ready handshake to the host register bank.
- Sits between the host config registers and the continuity checker, in the checker's clock domain.

Parameters:
- TCQ, 0.1, simulation clock-to-Q delay on all register assignments.
- SETTLE_CYC, 4, cycles waited after window close before sampling checker outputs (range 2..15).
- WIN_W, 32, width of the window sample counter.

Ports:
- clk_i  in  1  checker clock; sole clock.
- rst_i  in  1  synchronous reset, active-high.
- cfg_start_i  in  1  one-cycle pulse; start measurement.
- cfg_stop_i  in  1  one-cycle pulse; abort and return to IDLE.
- cfg_continuous_i  in  1  1 = restart a new window after each report.
- cfg_window_i  in  WIN_W  encoder samples per window; 0 is treated as 1.
- cfg_cnt_thresh_i  in  18  jump-count alarm threshold.
- eds_scan_en_i  in  1  system scan enable.
- src_encode_en_i  in  1  encoder sample strobe.
- chk_max_i  in  18  checker continuity max.
- chk_cnt_i  in  18  checker jump count.
- chk_err_lock_i  in  1  checker error lock.
- chk_warn_lock_i  in  1  checker warn lock.
- check_clean_o  out  1  clean pulse to the checker.
- check_scan_en_o  out  1  gated scan enable to the checker.
- rpt_valid_o  out  1  report valid.
- rpt_ready_i  in  1  report accepted.
- rpt_max_o  out  18  latched max.
- rpt_cnt_o  out  18  latched count.
- rpt_flags_o  out  4  bit0 err_lock, bit1 warn_lock, bit2 cnt>=thresh, bit3 partial.
- rpt_seq_o  out  16  window sequence number.
- busy_o  out  1  high whenever state is not IDLE.
- drop_o  out  1  sticky; a report was skipped.

Behaviour:
- Clocking and reset: single clock clk_i. rst_i is synchronous, active-high.
- Reset values: state IDLE; all outputs 0; rpt_seq_o 0; sample counter 0.
- IDLE: all outputs low except held report fields. cfg_start_i -> CLEAN.
- CLEAN: check_clean_o=1 for exactly 1 cycle; sample counter cleared -> ARM.
- ARM: waits for eds_scan_en_i=1, then -> RUN.
- RUN:
  - check_scan_en_o = eds_scan_en_i.
  - Counter increments on each src_encode_en_i.
  - Counter reaching cfg_window_i (the strobe making count == window) -> SETTLE, partial=0.
  - eds_scan_en_i falling -> SETTLE, partial=1.
- SETTLE:
  - check_scan_en_o=0.
  - Waits SETTLE_CYC cycles (counted from SETTLE entry), then -> CAPTURE.
- CAPTURE (1 cycle):
  - Latch rpt_max/cnt/locks from chk_* inputs.
  - flag2 = (chk_cnt_i >= cfg_cnt_thresh_i), unsigned 18-bit compare.
  - rpt_seq_o increments, wrapping 0xFFFF->0.
  - -> REPORT.
- REPORT:
  - rpt_valid_o=1.
  - All rpt_* fields held stable until the cycle valid&&ready.
  - On accept: if cfg_continuous_i -> CLEAN, else -> IDLE.
- Drop rule:
  - In continuous mode, if REPORT waits more than 1024 cycles, the report is discarded, drop_o is set (sticky until next cfg_start_i), and the FSM -> CLEAN.
  - The rpt_seq_o gap lets the host see the lost report.
- cfg_stop_i:
  - From any state -> IDLE next cycle; check_scan_en_o and rpt_valid_o drop immediately.
  - No clean pulse is issued.
  - Takes priority over cfg_start_i in the same cycle.
- cfg_start_i outside IDLE: ignored.
- Simultaneous src_encode_en_i and eds_scan_en_i fall in RUN: the sample is counted. If it reaches the window, partial=0.
- cfg_window_i / cfg_cnt_thresh_i: sampled into shadow registers in CLEAN; changes mid-window do not apply until the next window.
- Latency: cfg_start_i to check_clean_o = 1 cycle (registered). Window close to rpt_valid_o = SETTLE_CYC+2 cycles.

Decomposition:
- Shared package encode_check_pkg:
  - FSM state encoding (IDLE, CLEAN, ARM, RUN, SETTLE, CAPTURE, REPORT).
  - Flag bit indices.
  - Report timeout constant 1024.
  - Data width 18.
- One sub-module: encode_check_report_reg, which holds the report payload plus the valid/ready holding logic and timeout counter. FSM and window counter stay in the top.

Test Plan:
1. Single window: start, window=8, scan held 1, 8 strobes, checker max=0x00050 cnt=3, thresh=5, ready=1 -> one clean pulse; report max=0x50, cnt=3, flags=0000, seq=1; busy_o falls.
2. Threshold and locks: cnt=5, thresh=5, err_lock=1 -> flags=0101.
3. Partial window: window=100, scan falls after 40 strobes -> SETTLE entered, report flags bit3=1; check_scan_en_o=0 from the fall cycle.
4. Continuous mode with backpressure: ready low 10 cycles -> payload stable 10 cycles, then a second clean pulse, seq=2. Ready low 1100 cycles -> drop_o=1, next delivered seq skips one value.
5. Stop mid-RUN plus simultaneous start: cfg_stop_i and cfg_start_i in the same cycle -> IDLE, no clean pulse, busy_o=0 next cycle.
6. Reset mid-REPORT: rst_i=1 for one cycle -> rpt_valid_o=0, seq=0, state IDLE.

Source files
------------

// File: rtl/encode_check_pkg.sv
// Shared widths, FSM encoding, report flag positions and report payload layout for the
// encoder-check scheduler; purely declarative, no latency or backpressure of its own.
package encode_check_pkg;
    localparam int DATA_W      = 18;
    localparam int RPT_TIMEOUT = 1024;

    localparam int FLAG_ERR  = 0;
    localparam int FLAG_WARN = 1;
    localparam int FLAG_THR  = 2;
    localparam int FLAG_PART = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAN   = 3'd1;
    localparam logic [2:0] ST_ARM     = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;
    localparam logic [2:0] ST_CAPTURE = 3'd5;
    localparam logic [2:0] ST_REPORT  = 3'd6;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t       max;
        data_t       cnt;
        logic [3:0]  flags;
        logic [15:0] seq;
    } rpt_t;
endpackage

// File: rtl/encode_check_scheduler_if.sv
// Report channel from the scheduler to the host register bank; valid/ready, payload
// held stable by the master while valid is high and ready is low.
interface encode_check_scheduler_if;
    import encode_check_pkg::*;

    logic        rpt_valid;
    logic        rpt_ready;
    data_t       rpt_max;
    data_t       rpt_cnt;
    logic [3:0]  rpt_flags;
    logic [15:0] rpt_seq;

    modport master (
        output rpt_valid, rpt_max, rpt_cnt, rpt_flags, rpt_seq,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid, rpt_max, rpt_cnt, rpt_flags, rpt_seq,
        output rpt_ready
    );
endinterface

// File: rtl/encode_check_report_reg.sv
// Report payload register: latches checker results on capture, holds valid until accepted,
// a stop clears it, and in continuous mode a report left unaccepted past the timeout is discarded.
module encode_check_report_reg
    import encode_check_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  cap_i,
    input  logic  clr_i,
    input  logic  drop_clr_i,
    input  logic  continuous_i,
    input  logic  partial_i,
    input  data_t thresh_i,
    input  data_t chk_max_i,
    input  data_t chk_cnt_i,
    input  logic  chk_err_lock_i,
    input  logic  chk_warn_lock_i,
    encode_check_scheduler_if.master rpt,
    output logic  accept_o,
    output logic  timeout_o,
    output logic  drop_o
);
    localparam int TMO_W = $clog2(RPT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(RPT_TIMEOUT);

    rpt_t             pay_q, pay_d;
    logic             vld_q, vld_d;
    logic             drop_q, drop_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign accept_o  = vld_q && !clr_i && rpt.rpt_ready;
    // tmo_q equals the number of cycles already spent waiting, so this fires on the
    // first cycle beyond RPT_TIMEOUT cycles of unaccepted valid.
    assign timeout_o = vld_q && !clr_i && !rpt.rpt_ready && continuous_i && (tmo_q == TMO_MAX);

    always_comb begin
        pay_d  = pay_q;
        vld_d  = vld_q;
        drop_d = drop_q;
        tmo_d  = '0;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (cap_i) begin
            vld_d                 = 1'b1;
            pay_d.max             = chk_max_i;
            pay_d.cnt             = chk_cnt_i;
            pay_d.flags[FLAG_ERR]  = chk_err_lock_i;
            pay_d.flags[FLAG_WARN] = chk_warn_lock_i;
            pay_d.flags[FLAG_THR]  = (chk_cnt_i >= thresh_i);
            pay_d.flags[FLAG_PART] = partial_i;
            pay_d.seq             = pay_q.seq + 16'd1;
        end else if (accept_o || timeout_o) begin
            vld_d = 1'b0;
        end
        if (vld_q && vld_d) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        end
        if (drop_clr_i) begin
            drop_d = 1'b0;
        end else if (timeout_o) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pay_q  <= '0;
            vld_q  <= 1'b0;
            drop_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            pay_q  <= pay_d;
            vld_q  <= vld_d;
            drop_q <= drop_d;
            tmo_q  <= tmo_d;
        end
    end

    assign rpt.rpt_valid = vld_q && !clr_i;
    assign rpt.rpt_max   = pay_q.max;
    assign rpt.rpt_cnt   = pay_q.cnt;
    assign rpt.rpt_flags = pay_q.flags;
    assign rpt.rpt_seq   = pay_q.seq;
    assign drop_o        = drop_q;
endmodule

// File: rtl/encode_check_scheduler.sv
// Runs repeated encoder-continuity measurement windows: clean pulse 1 cycle after start,
// report valid SETTLE_CYC+2 cycles after window close, held until ready (or dropped on timeout).
module encode_check_scheduler
    import encode_check_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int WIN_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_start_i,
    input  logic             cfg_stop_i,
    input  logic             cfg_continuous_i,
    input  logic [WIN_W-1:0] cfg_window_i,
    input  data_t            cfg_cnt_thresh_i,
    input  logic             eds_scan_en_i,
    input  logic             src_encode_en_i,
    input  data_t            chk_max_i,
    input  data_t            chk_cnt_i,
    input  logic             chk_err_lock_i,
    input  logic             chk_warn_lock_i,
    output logic             check_clean_o,
    output logic             check_scan_en_o,
    encode_check_scheduler_if.master rpt,
    output logic             busy_o,
    output logic             drop_o
);
    logic [2:0]       state_q, state_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    data_t            thr_q, thr_d;
    logic [3:0]       settle_q, settle_d;
    logic             partial_q, partial_d;
    logic             start_acc;
    logic             rpt_accept;
    logic             rpt_timeout;
    logic [WIN_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + WIN_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        thr_d     = thr_q;
        settle_d  = settle_q;
        partial_d = partial_q;
        start_acc = 1'b0;
        if (cfg_stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start_i) begin
                        state_d   = ST_CLEAN;
                        start_acc = 1'b1;
                    end
                end
                ST_CLEAN: begin
                    cnt_d   = '0;
                    win_d   = (cfg_window_i == '0) ? WIN_W'(1) : cfg_window_i;
                    thr_d   = cfg_cnt_thresh_i;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (eds_scan_en_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    settle_d = '0;
                    if (src_encode_en_i) cnt_d = cnt_inc;
                    // A closing strobe wins over a coincident scan fall: the window is complete.
                    if (src_encode_en_i && (cnt_inc == win_q)) begin
                        state_d   = ST_SETTLE;
                        partial_d = 1'b0;
                    end else if (!eds_scan_en_i) begin
                        state_d   = ST_SETTLE;
                        partial_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == 4'(SETTLE_CYC - 1)) state_d = ST_CAPTURE;
                    else                                settle_d = settle_q + 4'd1;
                end
                ST_CAPTURE: state_d = ST_REPORT;
                ST_REPORT: begin
                    if (rpt_accept)       state_d = cfg_continuous_i ? ST_CLEAN : ST_IDLE;
                    else if (rpt_timeout) state_d = ST_CLEAN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            thr_q     <= '0;
            settle_q  <= '0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            thr_q     <= thr_d;
            settle_q  <= settle_d;
            partial_q <= partial_d;
        end
    end

    assign check_clean_o   = (state_q == ST_CLEAN);
    assign check_scan_en_o = (state_q == ST_RUN) && eds_scan_en_i && !cfg_stop_i;
    assign busy_o          = (state_q != ST_IDLE);

    encode_check_report_reg u_report (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cap_i           (state_q == ST_CAPTURE),
        .clr_i           (cfg_stop_i),
        .drop_clr_i      (start_acc),
        .continuous_i    (cfg_continuous_i),
        .partial_i       (partial_q),
        .thresh_i        (thr_q),
        .chk_max_i       (chk_max_i),
        .chk_cnt_i       (chk_cnt_i),
        .chk_err_lock_i  (chk_err_lock_i),
        .chk_warn_lock_i (chk_warn_lock_i),
        .rpt             (rpt),
        .accept_o        (rpt_accept),
        .timeout_o       (rpt_timeout),
        .drop_o          (drop_o)
    );
endmodule
